// File: rtl/ring_osc_meas_sched.sv
// Ring-oscillator bank sequencer: enables one ring at a time, lets it settle, then counts prescaled edges over a gate window.
// Back-to-back scan of all rings is built only when RO_AUTO_SCAN_EN is defined; otherwise auto_scan is ignored.
`timescale 1ns/100ps
module ring_osc_meas_sched #(
  parameter int N_OSC      = 12,
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 16,
  parameter int SETTLE_CYC = 16,
  parameter int PRESC_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        osc_sel,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              auto_scan,
  input  logic [N_OSC-1:0]  osc_in,
  output logic [N_OSC-1:0]  osc_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [3:0]        count_idx,
  output logic              ovf,
  output logic              err
);

  localparam int IDX_W = 4;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_OSC - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    cur_idx_r, cur_idx_s;
  logic [GATE_W-1:0]   gate_lat_r, gate_lat_s;
  logic [GATE_W-1:0]   gate_cnt_r, gate_cnt_s;
  logic [SET_W-1:0]    settle_cnt_r, settle_cnt_s;
  logic [CNT_W-1:0]    edge_cnt_r, edge_cnt_s;
  logic                ovf_acc_r, ovf_acc_s;
  logic [N_OSC-1:0]    osc_en_r, osc_en_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic [CNT_W-1:0]    count_r, count_s;
  logic [IDX_W-1:0]    count_idx_r, count_idx_s;
  logic                ovf_r, ovf_s;
  logic                err_r, err_s;
  logic                scan_req_s;
  logic [15:0]         osc_pad_s;
  logic                sel_osc_s;
  logic                ring_rst_s;
  logic                ring_msb_s;
  logic [1:0]          sync_r;
  logic                ev_d_r;
  logic                ev_s;

`ifdef RO_AUTO_SCAN_EN
  logic scan_r, scan_s;
  assign scan_req_s = auto_scan;
`else
  logic unused_auto_scan_s;
  assign unused_auto_scan_s = auto_scan;
  assign scan_req_s         = 1'b0;
`endif

  for (genvar i = 0; i < 16; i++) begin : g_pad
    if (i < N_OSC) begin : g_ring
      assign osc_pad_s[i] = osc_in[i];
    end else begin : g_tie
      assign osc_pad_s[i] = 1'b0;
    end
  end

  assign sel_osc_s  = osc_pad_s[cur_idx_r];
  assign ring_rst_s = rst | ~(|osc_en_r);

  // Ring-clocked prescaler, held cleared whenever no ring is enabled.
  if (PRESC_LOG2 == 0) begin : g_no_presc
    assign ring_msb_s = sel_osc_s;
  end else begin : g_presc
    logic [PRESC_LOG2-1:0] presc_r;
    always_ff @(posedge sel_osc_s or posedge ring_rst_s) begin
      if (ring_rst_s) presc_r <= {PRESC_LOG2{1'b0}};
      else            presc_r <= presc_r + PRESC_LOG2'(1);
    end
    assign ring_msb_s = presc_r[PRESC_LOG2-1];
  end

  // Two-flop synchroniser into clk plus rising-edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b00;
      ev_d_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], ring_msb_s};
      ev_d_r <= sync_r[1];
    end
  end
  assign ev_s = sync_r[1] & ~ev_d_r;

  // Next-state and next-output logic; abort overrides every transition.
  always_comb begin
    state_s      = state_r;
    cur_idx_s    = cur_idx_r;
    gate_lat_s   = gate_lat_r;
    gate_cnt_s   = gate_cnt_r;
    settle_cnt_s = settle_cnt_r;
    edge_cnt_s   = edge_cnt_r;
    ovf_acc_s    = ovf_acc_r;
    count_s      = count_r;
    count_idx_s  = count_idx_r;
    ovf_s        = ovf_r;
    err_s        = err_r;
    done_s       = 1'b0;
`ifdef RO_AUTO_SCAN_EN
    scan_s       = scan_r;
`endif
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !scan_req_s && (osc_sel > LAST_IDX)) begin
            err_s       = 1'b1;
            count_s     = {CNT_W{1'b0}};
            count_idx_s = osc_sel;
            done_s      = 1'b1;
          end else if (start) begin
            err_s        = 1'b0;
            ovf_s        = 1'b0;
            cur_idx_s    = scan_req_s ? {IDX_W{1'b0}} : osc_sel;
            gate_lat_s   = gate_cycles;
            settle_cnt_s = {SET_W{1'b0}};
            state_s      = ST_SETTLE;
`ifdef RO_AUTO_SCAN_EN
            scan_s       = scan_req_s;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            gate_cnt_s = gate_lat_r;
            edge_cnt_s = {CNT_W{1'b0}};
            ovf_acc_s  = 1'b0;
            state_s    = ST_MEASURE;
          end else begin
            settle_cnt_s = settle_cnt_r + SET_W'(1);
          end
        end
        ST_MEASURE: begin
          // A zero-length window skips edge counting entirely.
          if (gate_cnt_r != {GATE_W{1'b0}}) begin
            gate_cnt_s = gate_cnt_r - GATE_W'(1);
            if (ev_s && (edge_cnt_r == CNT_MAX)) begin
              ovf_acc_s = 1'b1;
            end else if (ev_s) begin
              edge_cnt_s = edge_cnt_r + CNT_W'(1);
            end else begin
              edge_cnt_s = edge_cnt_r;
            end
          end else begin
            gate_cnt_s = gate_cnt_r;
          end
          if (gate_cnt_r <= GATE_W'(1)) state_s = ST_REPORT;
          else                          state_s = ST_MEASURE;
        end
        ST_REPORT: begin
          count_s     = edge_cnt_r;
          count_idx_s = cur_idx_r;
          ovf_s       = ovf_acc_r;
          done_s      = 1'b1;
`ifdef RO_AUTO_SCAN_EN
          if (scan_r && (cur_idx_r != LAST_IDX)) begin
            cur_idx_s    = cur_idx_r + IDX_W'(1);
            settle_cnt_s = {SET_W{1'b0}};
            state_s      = ST_SETTLE;
          end else begin
            scan_s  = 1'b0;
            state_s = ST_IDLE;
          end
`else
          state_s = ST_IDLE;
`endif
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
    if ((state_s == ST_SETTLE) || (state_s == ST_MEASURE)) osc_en_s = N_OSC'(1) << cur_idx_s;
    else                                                   osc_en_s = {N_OSC{1'b0}};
    busy_s = (state_s != ST_IDLE);
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cur_idx_r    <= {IDX_W{1'b0}};
      gate_lat_r   <= {GATE_W{1'b0}};
      gate_cnt_r   <= {GATE_W{1'b0}};
      settle_cnt_r <= {SET_W{1'b0}};
      edge_cnt_r   <= {CNT_W{1'b0}};
      ovf_acc_r    <= 1'b0;
      osc_en_r     <= {N_OSC{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      count_r      <= {CNT_W{1'b0}};
      count_idx_r  <= {IDX_W{1'b0}};
      ovf_r        <= 1'b0;
      err_r        <= 1'b0;
`ifdef RO_AUTO_SCAN_EN
      scan_r       <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      cur_idx_r    <= cur_idx_s;
      gate_lat_r   <= gate_lat_s;
      gate_cnt_r   <= gate_cnt_s;
      settle_cnt_r <= settle_cnt_s;
      edge_cnt_r   <= edge_cnt_s;
      ovf_acc_r    <= ovf_acc_s;
      osc_en_r     <= osc_en_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      count_r      <= count_s;
      count_idx_r  <= count_idx_s;
      ovf_r        <= ovf_s;
      err_r        <= err_s;
`ifdef RO_AUTO_SCAN_EN
      scan_r       <= scan_s;
`endif
    end
  end

  assign osc_en    = osc_en_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign count     = count_r;
  assign count_idx = count_idx_r;
  assign ovf       = ovf_r;
  assign err       = err_r;

endmodule

// File: tb/tb_ring_osc_meas_sched.sv
// Directed bench for ring_osc_meas_sched: three instances (no prescaler, /16 prescaler, 4-bit counter).
`timescale 1ns/100ps
module tb_ring_osc_meas_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic [3:0]  osc_sel;
  logic [15:0] gate_cycles;
  logic        auto_scan;
  logic        start_a, start_b, start_c;
  logic        slow_osc = 1'b0;
  logic        fast_osc = 1'b0;
  logic [11:0] osc_in;

  logic [11:0] osc_en_a, osc_en_b, osc_en_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [15:0] count_a, count_b;
  logic [3:0]  count_c;
  logic [3:0]  count_idx_a, count_idx_b, count_idx_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        err_a, err_b, err_c;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [11:0] en_seen;
  bit          multi_hot;
  int          lat;
  bit          got;
  int          n_done;
  int          dn;

`ifdef RO_AUTO_SCAN_EN
  localparam int SCAN_N = 12;
`else
  localparam int SCAN_N = 1;
`endif

  always #5 clk = ~clk;
  always #20 slow_osc = ~slow_osc;
  initial begin
    #0.5;
    forever #1 fast_osc = ~fast_osc;
  end
  // Ring 5 is the 2 ns ring, every other ring runs at 40 ns.
  assign osc_in = {{6{slow_osc}}, fast_osc, {5{slow_osc}}};

  ring_osc_meas_sched #(.PRESC_LOG2(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .osc_sel(osc_sel),
    .gate_cycles(gate_cycles), .auto_scan(auto_scan), .osc_in(osc_in),
    .osc_en(osc_en_a), .busy(busy_a), .done(done_a), .count(count_a),
    .count_idx(count_idx_a), .ovf(ovf_a), .err(err_a));

  ring_osc_meas_sched #(.PRESC_LOG2(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .osc_sel(osc_sel),
    .gate_cycles(gate_cycles), .auto_scan(auto_scan), .osc_in(osc_in),
    .osc_en(osc_en_b), .busy(busy_b), .done(done_b), .count(count_b),
    .count_idx(count_idx_b), .ovf(ovf_b), .err(err_b));

  ring_osc_meas_sched #(.CNT_W(4), .PRESC_LOG2(0)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort), .osc_sel(osc_sel),
    .gate_cycles(gate_cycles), .auto_scan(auto_scan), .osc_in(osc_in),
    .osc_en(osc_en_c), .busy(busy_c), .done(done_c), .count(count_c),
    .count_idx(count_idx_c), .ovf(ovf_c), .err(err_c));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start on one instance, then count cycles until its done is seen.
  task automatic run_meas(input int which, input int budget, output int n_cyc, output bit seen);
    logic [11:0] en;
    logic        d;
    en_seen   = 12'h000;
    multi_hot = 1'b0;
    seen      = 1'b0;
    n_cyc     = 0;
    @(posedge clk); #1;
    case (which)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    while (!seen && n_cyc < budget) begin
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      n_cyc++;
      case (which)
        0:       begin en = osc_en_a; d = done_a; end
        1:       begin en = osc_en_b; d = done_b; end
        default: begin en = osc_en_c; d = done_c; end
      endcase
      en_seen = en_seen | en;
      if ((en & (en - 12'd1)) != 12'd0) multi_hot = 1'b1;
      if (d) seen = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; osc_sel = 4'd0; gate_cycles = 16'd0; auto_scan = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    #12;
    check_eq("rst_osc_en", 32'(osc_en_a), 32'd0);
    check_eq("rst_busy",   32'(busy_a),   32'd0);
    check_eq("rst_done",   32'(done_a),   32'd0);
    check_eq("rst_count",  32'(count_a),  32'd0);
    check_eq("rst_err",    32'(err_a),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single measurement, ring 0 (40 ns), gate 100.
    osc_sel = 4'd0; gate_cycles = 16'd100;
    run_meas(0, 200, lat, got);
    check_eq("t1_done_seen", 32'(got), 32'd1);
    check_eq("t1_latency", 32'(lat), 32'd118);
    check_eq("t1_count_24_to_26", 32'(count_a >= 16'd24 && count_a <= 16'd26), 32'd1);
    check_eq("t1_count_idx", 32'(count_idx_a), 32'd0);
    check_eq("t1_ovf", 32'(ovf_a), 32'd0);
    check_eq("t1_osc_en_seen", 32'(en_seen), 32'h001);
    check_eq("t1_busy_after", 32'(busy_a), 32'd0);

    // Zero-length window.
    gate_cycles = 16'd0;
    run_meas(0, 60, lat, got);
    check_eq("gate0_latency", 32'(lat), 32'd19);
    check_eq("gate0_count", 32'(count_a), 32'd0);

    // Out-of-range ring index.
    osc_sel = 4'd13; gate_cycles = 16'd100;
    run_meas(0, 20, lat, got);
    check_eq("err_latency", 32'(lat), 32'd1);
    check_eq("err_flag", 32'(err_a), 32'd1);
    check_eq("err_count", 32'(count_a), 32'd0);
    check_eq("err_count_idx", 32'(count_idx_a), 32'd13);
    check_eq("err_osc_en_seen", 32'(en_seen), 32'd0);

    // Prescaled fast ring 5 on the /16 instance.
    osc_sel = 4'd5; gate_cycles = 16'd1000;
    run_meas(1, 1100, lat, got);
    check_eq("t2_latency", 32'(lat), 32'd1018);
    check_eq("t2_count_311_to_313", 32'(count_b >= 16'd311 && count_b <= 16'd313), 32'd1);
    check_eq("t2_count_idx", 32'(count_idx_b), 32'd5);
    check_eq("t2_osc_en_seen", 32'(en_seen), 32'h020);
    check_eq("t2_ovf", 32'(ovf_b), 32'd0);

    // Saturation on the 4-bit counter instance.
    osc_sel = 4'd0; gate_cycles = 16'd200;
    run_meas(2, 300, lat, got);
    check_eq("t3_latency", 32'(lat), 32'd218);
    check_eq("t3_count", 32'(count_c), 32'd15);
    check_eq("t3_ovf", 32'(ovf_c), 32'd1);

    // Abort in the middle of MEASURE.
    osc_sel = 4'd1; gate_cycles = 16'd50;
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    check_eq("abort_pre_osc_en", 32'(osc_en_a), 32'h002);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check_eq("abort_osc_en", 32'(osc_en_a), 32'd0);
    check_eq("abort_busy", 32'(busy_a), 32'd0);
    dn = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      dn += int'(done_a);
    end
    check_eq("abort_no_done", 32'(dn), 32'd0);
    check_eq("abort_count_kept", 32'(count_a), 32'd0);
    check_eq("abort_idx_kept", 32'(count_idx_a), 32'd13);

    // Start and abort together in IDLE: abort wins.
    start_a = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start_a = 1'b0; abort = 1'b0;
    check_eq("start_abort_busy", 32'(busy_a), 32'd0);

    // Normal measurement after abort.
    osc_sel = 4'd2; gate_cycles = 16'd40;
    run_meas(0, 100, lat, got);
    check_eq("post_abort_latency", 32'(lat), 32'd58);
    check_eq("post_abort_count_9_to_11", 32'(count_a >= 16'd9 && count_a <= 16'd11), 32'd1);
    check_eq("post_abort_idx", 32'(count_idx_a), 32'd2);
    check_eq("post_abort_err", 32'(err_a), 32'd0);

    // Scan request (honoured only with RO_AUTO_SCAN_EN).
    osc_sel = 4'd3; gate_cycles = 16'd20; auto_scan = 1'b1;
    multi_hot = 1'b0; n_done = 0;
    @(posedge clk); #1; start_a = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      start_a = 1'b0; auto_scan = 1'b0;
      if ((osc_en_a & (osc_en_a - 12'd1)) != 12'd0) multi_hot = 1'b1;
      if (done_a) begin
        check_eq("scan_idx", 32'(count_idx_a), (SCAN_N == 12) ? 32'(n_done) : 32'd3);
        n_done++;
      end
    end
    check_eq("scan_done_count", 32'(n_done), 32'(SCAN_N));
    check_eq("scan_one_hot", 32'(multi_hot), 32'd0);
    check_eq("scan_busy_end", 32'(busy_a), 32'd0);

    // Asynchronous reset during SETTLE.
    osc_sel = 4'd0; gate_cycles = 16'd10;
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("pre_rst_osc_en", 32'(osc_en_a), 32'h001);
    #2; rst = 1'b1;
    #1;
    check_eq("arst_osc_en", 32'(osc_en_a), 32'd0);
    check_eq("arst_busy", 32'(busy_a), 32'd0);
    check_eq("arst_count", 32'(count_a), 32'd0);
    check_eq("arst_count_idx", 32'(count_idx_a), 32'd0);
    check_eq("arst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
